// File: rtl/column_cursor_ctrl_pkg.sv
// Shared Connect4 cursor constants, FSM encodings and column wrap helpers.
package column_cursor_ctrl_pkg;

    localparam int unsigned NUM_COLS = 7;
    localparam int unsigned COL_W    = 3;

    localparam logic [COL_W-1:0] CENTER_COL = COL_W'(NUM_COLS / 2);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_REPEAT    = 2'd2;
    localparam logic [1:0] ST_DROP_WAIT = 2'd3;

    // Next column to the right, wrapping past the last column to 0.
    function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] col);
        return (col == LAST_COL) ? '0 : col + COL_W'(1);
    endfunction

    // Next column to the left, wrapping below 0 to the last column.
    function automatic logic [COL_W-1:0] col_dec(input logic [COL_W-1:0] col);
        return (col == '0) ? LAST_COL : col - COL_W'(1);
    endfunction

endpackage

// File: rtl/column_cursor_ctrl_if.sv
// Drop request handshake between the cursor controller and the board stage.
interface column_cursor_ctrl_if;
    import column_cursor_ctrl_pkg::*;

    logic             drop_valid;
    logic [COL_W-1:0] drop_col;
    logic             drop_ready;
    logic             drop_reject;

    modport master (
        output drop_valid,
        output drop_col,
        output drop_reject,
        input  drop_ready
    );

    modport slave (
        input  drop_valid,
        input  drop_col,
        input  drop_reject,
        output drop_ready
    );

endinterface

// File: rtl/column_cursor_ctrl_rising_edge_detect.sv
// Single-cycle pulse on the 0->1 transition of a debounced level.
module column_cursor_ctrl_rising_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse_c
);

    logic prev_q;

    // Level history, updated every cycle regardless of controller state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign pulse_c = level & ~prev_q;

endmodule

// File: rtl/column_cursor_ctrl.sv
// Cursor column control with wrap, hold auto-repeat and drop request handshake.
module column_cursor_ctrl
    import column_cursor_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_drop,
    input  logic                enable,
    input  logic [NUM_COLS-1:0] column_full,
    output logic [COL_W-1:0]    cursor_col,
    column_cursor_ctrl_if.master drop_if
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic rise_left, rise_right, rise_drop;

    logic [1:0]       state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [COL_W-1:0] cursor_q, cursor_nxt;
    logic             held_left_q, held_left_nxt;
    logic             drop_valid_q, drop_valid_nxt;
    logic [COL_W-1:0] drop_col_q, drop_col_nxt;
    logic             drop_reject_q, drop_reject_nxt;

    logic move_left, move_right;
    logic held_lvl, opp_lvl;

    column_cursor_ctrl_rising_edge_detect u_edge_left (
        .clk(clk), .rst_n(rst_n), .level(btn_left), .pulse_c(rise_left)
    );
    column_cursor_ctrl_rising_edge_detect u_edge_right (
        .clk(clk), .rst_n(rst_n), .level(btn_right), .pulse_c(rise_right)
    );
    column_cursor_ctrl_rising_edge_detect u_edge_drop (
        .clk(clk), .rst_n(rst_n), .level(btn_drop), .pulse_c(rise_drop)
    );

    // State, counter, cursor and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cursor_q      <= CENTER_COL;
            held_left_q   <= 1'b0;
            drop_valid_q  <= 1'b0;
            drop_col_q    <= '0;
            drop_reject_q <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            cnt_q         <= cnt_nxt;
            cursor_q      <= cursor_nxt;
            held_left_q   <= held_left_nxt;
            drop_valid_q  <= drop_valid_nxt;
            drop_col_q    <= drop_col_nxt;
            drop_reject_q <= drop_reject_nxt;
        end
    end

    // Next-state: drop events take priority over moves; DROP_WAIT ignores buttons.
    always_comb begin
        state_nxt       = state_q;
        cnt_nxt         = cnt_q;
        cursor_nxt      = cursor_q;
        held_left_nxt   = held_left_q;
        drop_valid_nxt  = drop_valid_q;
        drop_col_nxt    = drop_col_q;
        drop_reject_nxt = 1'b0;
        move_left       = 1'b0;
        move_right      = 1'b0;
        held_lvl        = held_left_q ? btn_left  : btn_right;
        opp_lvl         = held_left_q ? btn_right : btn_left;

        if (state_q == ST_DROP_WAIT) begin
            if (drop_if.drop_ready) begin
                drop_valid_nxt = 1'b0;
                state_nxt      = ST_IDLE;
            end
        end else if (rise_drop && enable) begin
            cnt_nxt = '0;
            if (!column_full[cursor_q]) begin
                drop_valid_nxt = 1'b1;
                drop_col_nxt   = cursor_q;
                state_nxt      = ST_DROP_WAIT;
            end else begin
                drop_reject_nxt = 1'b1;
                state_nxt       = ST_IDLE;
            end
        end else if (state_q == ST_IDLE) begin
            if (enable && (rise_left ^ rise_right)) begin
                move_left     = rise_left;
                move_right    = rise_right;
                held_left_nxt = rise_left;
                cnt_nxt       = '0;
                state_nxt     = ST_HOLD;
            end
        end else begin
            if (!held_lvl || opp_lvl || !enable) begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end else if (cnt_q == ((state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                move_left  = held_left_q;
                move_right = ~held_left_q;
                cnt_nxt    = '0;
                state_nxt  = ST_REPEAT;
            end else begin
                cnt_nxt = cnt_q + CNT_W'(1);
            end
        end

        if (move_left) begin
            cursor_nxt = col_dec(cursor_q);
        end else if (move_right) begin
            cursor_nxt = col_inc(cursor_q);
        end
    end

    assign cursor_col          = cursor_q;
    assign drop_if.drop_valid  = drop_valid_q;
    assign drop_if.drop_col    = drop_col_q;
    assign drop_if.drop_reject = drop_reject_q;

endmodule

// File: tb/tb_column_cursor_ctrl.sv
// Self-checking bench for column_cursor_ctrl with a cursor-move scoreboard.
module tb_column_cursor_ctrl;
    import column_cursor_ctrl_pkg::*;

    localparam int unsigned HOLD_D = 5;
    localparam int unsigned REP_P  = 3;
    localparam int unsigned CW     = 4;

    typedef struct {
        int               cyc;
        logic [COL_W-1:0] col;
    } move_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                btn_left, btn_right, btn_drop, enable;
    logic [NUM_COLS-1:0] column_full;
    logic [COL_W-1:0]    cursor_col;

    column_cursor_ctrl_if dif();

    column_cursor_ctrl #(
        .HOLD_DELAY(HOLD_D), .REPEAT_PERIOD(REP_P), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
        .enable(enable), .column_full(column_full),
        .cursor_col(cursor_col), .drop_if(dif)
    );

    always #5 clk = ~clk;

    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    int               model_col;
    bit               mon_en = 1'b0;
    logic [COL_W-1:0] last_col = '0;
    move_t            exp_q[$];
    move_t            e_mon;

    always @(posedge clk) cyc++;

    // Every visible cursor change is matched against the next expected move.
    always @(negedge clk) begin
        if (mon_en && cursor_col !== last_col) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL move_unexpected: cursor_col=%0d at cycle %0d, required no move", cursor_col, cyc);
            end else begin
                e_mon = exp_q.pop_front();
                if (cursor_col !== e_mon.col || cyc != e_mon.cyc) begin
                    errors++;
                    $display("FAIL move: got col=%0d cycle=%0d, required col=%0d cycle=%0d",
                             cursor_col, cyc, e_mon.col, e_mon.cyc);
                end
            end
        end
        last_col = cursor_col;
    end

    function automatic int wrap_right(input int c);
        return (c == NUM_COLS - 1) ? 0 : c + 1;
    endfunction

    function automatic int wrap_left(input int c);
        return (c == 0) ? NUM_COLS - 1 : c - 1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        mon_en           = 1'b0;
        rst_n            = 1'b0;
        btn_left         = 1'b0;
        btn_right        = 1'b0;
        btn_drop         = 1'b0;
        enable           = 1'b1;
        column_full      = '0;
        dif.drop_ready   = 1'b0;
        exp_q.delete();
        step(2);
        rst_n     = 1'b1;
        model_col = 3;
        step(1);
        mon_en = 1'b1;
    endtask

    // One-cycle press of a direction button; the move is expected next cycle.
    task automatic tap(input bit right);
        if (right) begin
            btn_right = 1'b1;
            model_col = wrap_right(model_col);
        end else begin
            btn_left  = 1'b1;
            model_col = wrap_left(model_col);
        end
        exp_q.push_back('{cyc + 1, COL_W'(model_col)});
        step(1);
        btn_right = 1'b0;
        btn_left  = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cursor_col !== 3'd3) begin
            errors++; $display("FAIL reset_cursor: got %0d required 3", cursor_col);
        end
        checks++;
        if (dif.drop_valid !== 1'b0 || dif.drop_col !== 3'd0 || dif.drop_reject !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop: got valid=%0b col=%0d reject=%0b required 0/0/0",
                     dif.drop_valid, dif.drop_col, dif.drop_reject);
        end
    endtask

    task automatic test_single_move();
        do_reset();
        tap(1'b1);
        step(5);
        checks++;
        if (cursor_col !== 3'd4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_move: got col=%0d pending=%0d required col=4 pending=0", cursor_col, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        tap(1'b1);
        tap(1'b1);
        tap(1'b1);
        checks++;
        if (cursor_col !== 3'd0) begin
            errors++; $display("FAIL wrap_right: got %0d required 0", cursor_col);
        end
        tap(1'b0);
        step(2);
        checks++;
        if (cursor_col !== 3'd6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_left: got col=%0d pending=%0d required col=6 pending=0", cursor_col, exp_q.size());
        end
    endtask

    task automatic test_hold_repeat();
        int c0;
        do_reset();
        c0 = cyc;
        btn_left = 1'b1;
        exp_q.push_back('{c0 + 1,  3'd2});
        exp_q.push_back('{c0 + 6,  3'd1});
        exp_q.push_back('{c0 + 9,  3'd0});
        exp_q.push_back('{c0 + 12, 3'd6});
        exp_q.push_back('{c0 + 15, 3'd5});
        step(15);
        btn_left = 1'b0;
        step(8);
        checks++;
        if (cursor_col !== 3'd5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_repeat: got col=%0d pending=%0d required col=5 pending=0", cursor_col, exp_q.size());
        end
    endtask

    task automatic test_drop_handshake();
        int valid_cycles = 0;
        do_reset();
        tap(1'b0);
        btn_drop = 1'b1;
        step(1);
        btn_drop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dif.drop_ready = (i == 4);
            btn_right      = (i % 2 == 0) && (i < 4);
            if (dif.drop_valid === 1'b1) valid_cycles++;
            checks++;
            if (dif.drop_valid !== 1'b1 || dif.drop_col !== 3'd2 || dif.drop_reject !== 1'b0) begin
                errors++;
                $display("FAIL drop_pending[%0d]: got valid=%0b col=%0d reject=%0b required 1/2/0",
                         i, dif.drop_valid, dif.drop_col, dif.drop_reject);
            end
            step(1);
        end
        dif.drop_ready = 1'b0;
        btn_right      = 1'b0;
        checks++;
        if (dif.drop_valid !== 1'b0 || valid_cycles != 5) begin
            errors++;
            $display("FAIL drop_accept: got valid=%0b high_cycles=%0d required 0 and 5", dif.drop_valid, valid_cycles);
        end
        step(3);
        checks++;
        if (cursor_col !== 3'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drop_freeze: got col=%0d pending=%0d required col=2 pending=0", cursor_col, exp_q.size());
        end
    endtask

    task automatic test_reject();
        do_reset();
        tap(1'b0);
        column_full = 7'b0000100;
        btn_drop    = 1'b1;
        step(1);
        btn_drop = 1'b0;
        checks++;
        if (dif.drop_reject !== 1'b1 || dif.drop_valid !== 1'b0) begin
            errors++;
            $display("FAIL reject_pulse: got reject=%0b valid=%0b required 1/0", dif.drop_reject, dif.drop_valid);
        end
        step(1);
        checks++;
        if (dif.drop_reject !== 1'b0 || dif.drop_valid !== 1'b0) begin
            errors++;
            $display("FAIL reject_end: got reject=%0b valid=%0b required 0/0", dif.drop_reject, dif.drop_valid);
        end
        enable   = 1'b0;
        btn_drop = 1'b1;
        step(1);
        btn_drop = 1'b0;
        checks++;
        if (dif.drop_reject !== 1'b0 || dif.drop_valid !== 1'b0) begin
            errors++;
            $display("FAIL disabled_drop: got reject=%0b valid=%0b required 0/0", dif.drop_reject, dif.drop_valid);
        end
        enable = 1'b1;
    endtask

    task automatic test_simultaneous();
        do_reset();
        btn_left  = 1'b1;
        btn_right = 1'b1;
        step(1);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        step(1);
        enable    = 1'b0;
        btn_right = 1'b1;
        step(1);
        btn_right = 1'b0;
        step(3);
        enable = 1'b1;
        checks++;
        if (cursor_col !== 3'd3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL no_move: got col=%0d pending=%0d required col=3 pending=0", cursor_col, exp_q.size());
        end
    endtask

    task automatic test_reset_in_drop_wait();
        do_reset();
        tap(1'b1);
        btn_drop = 1'b1;
        step(1);
        btn_drop = 1'b0;
        step(2);
        checks++;
        if (dif.drop_valid !== 1'b1 || dif.drop_col !== 3'd4) begin
            errors++;
            $display("FAIL pre_reset_drop: got valid=%0b col=%0d required 1/4", dif.drop_valid, dif.drop_col);
        end
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dif.drop_valid !== 1'b0 || dif.drop_col !== 3'd0 || cursor_col !== 3'd3) begin
            errors++;
            $display("FAIL async_reset: got valid=%0b col=%0d cursor=%0d required 0/0/3",
                     dif.drop_valid, dif.drop_col, cursor_col);
        end
        step(1);
        rst_n     = 1'b1;
        model_col = 3;
        step(1);
        mon_en = 1'b1;
        tap(1'b0);
        step(1);
        checks++;
        if (cursor_col !== 3'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_move: got col=%0d pending=%0d required col=2 pending=0", cursor_col, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_wrap();
        test_hold_repeat();
        test_drop_handshake();
        test_reject();
        test_simultaneous();
        test_reset_in_drop_wait();
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
